// File: rtl/nes_button_events.sv
// nes_button_events
//   Turns valid 8-bit NES button samples into a stream of press / release /
//   auto-repeat events. Each accepted sample is scanned one slot per cycle.
//   Slots 0..7 cover buttons 0..7. Slot 8 holds the optional repeat event.
//   Events are queued in a small FIFO that has a ready/valid output.
//
// Configuration macro: NES_EVENTS_REPEAT_EN
//   defined   -> repeat tracker and slot 8 are built
//   undefined -> no repeat tracker; REPEAT_DELAY / REPEAT_RATE are ignored
//
// Ports
//   clk            : clock, rising edge
//   i_rst_n        : synchronous active-low reset
//   i_valid        : one-cycle strobe, i_buttons holds a new sample
//   i_buttons[7:0] : 1 = pressed (A,B,Select,Start,Up,Down,Left,Right)
//   o_event_valid  : FIFO not empty
//   i_event_ready  : consumer accepts the head event
//   o_event_button : button index of the head event
//   o_event_kind   : 0 press, 1 release, 2 repeat
//   o_buttons_held : last accepted sample
//   o_busy         : scanner active, new samples are dropped
//   o_overflow     : sticky, a sample was dropped
module nes_button_events #(
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 6,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_buttons,
  output logic       o_event_valid,
  input  logic       i_event_ready,
  output logic [2:0] o_event_button,
  output logic [1:0] o_event_kind,
  output logic [7:0] o_buttons_held,
  output logic       o_busy,
  output logic       o_overflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [1:0] KIND_PRESS   = 2'd0;
  localparam logic [1:0] KIND_RELEASE = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RPT  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [2:0]     r_slot;
  logic [7:0]     r_press_mask;
  logic [7:0]     r_rel_mask;
  logic [7:0]     r_held;
  logic           r_overflow;

  logic [4:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;

  logic           w_accept;
  logic [7:0]     w_new_press;
  logic [7:0]     w_new_rel;
  logic           w_need_push;
  logic [4:0]     w_push_data;
  logic           w_full;
  logic           w_stall;
  logic           w_push;
  logic           w_pop;
  logic           w_not_empty;
  logic [4:0]     w_head;

  assign w_accept    = i_valid && (r_state == ST_IDLE);
  assign w_new_press = i_buttons & ~r_held;
  assign w_new_rel   = ~i_buttons & r_held;

  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_not_empty = (r_count != {CW{1'b0}});
  // A pop in the same cycle cannot free a slot for the push: fullness is
  // taken from the registered count only.
  assign w_stall     = w_need_push && w_full;
  assign w_push      = w_need_push && !w_full;
  assign w_pop       = w_not_empty && i_event_ready;
  assign w_head      = r_mem[r_rptr];

`ifdef NES_EVENTS_REPEAT_EN
  localparam logic [1:0] KIND_REPEAT = 2'd2;

  logic       r_rpt_active;
  logic [2:0] r_rpt_btn;
  logic [7:0] r_rpt_cnt;
  logic       r_fire;

  // Highest set bit wins when several buttons go down in the same sample.
  function automatic logic [2:0] f_highest(input logic [7:0] mask);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // Repeat tracker, evaluated once per accepted sample
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_rpt_active <= 1'b0;
      r_rpt_btn    <= 3'd0;
      r_rpt_cnt    <= 8'd0;
      r_fire       <= 1'b0;
    end else if (w_accept) begin
      if (w_new_press != 8'd0) begin
        r_rpt_btn    <= f_highest(w_new_press);
        r_rpt_cnt    <= 8'(REPEAT_DELAY);
        r_rpt_active <= 1'b1;
        r_fire       <= 1'b0;
      end else if (r_rpt_active && i_buttons[r_rpt_btn]) begin
        // Counter reaching zero fires and reloads, so it never wraps.
        if (r_rpt_cnt <= 8'd1) begin
          r_fire    <= 1'b1;
          r_rpt_cnt <= 8'(REPEAT_RATE);
        end else begin
          r_fire    <= 1'b0;
          r_rpt_cnt <= r_rpt_cnt - 8'd1;
        end
      end else begin
        r_rpt_active <= 1'b0;
        r_fire       <= 1'b0;
      end
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (REPEAT_DELAY != 0) ^ (REPEAT_RATE != 0);
`endif

  // State register, slot counter, sample latch and overflow flag
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_slot       <= 3'd0;
      r_press_mask <= 8'd0;
      r_rel_mask   <= 8'd0;
      r_held       <= 8'd0;
      r_overflow   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_slot       <= 3'd0;
        r_press_mask <= w_new_press;
        r_rel_mask   <= w_new_rel;
        r_held       <= i_buttons;
      end else if ((r_state == ST_SCAN) && !w_stall && (r_slot != 3'd7)) begin
        r_slot <= r_slot + 3'd1;
      end
      if (i_valid && (r_state != ST_IDLE)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SCAN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (w_stall) begin
          w_state_nxt = ST_SCAN;
        end else if (r_slot == 3'd7) begin
`ifdef NES_EVENTS_REPEAT_EN
          w_state_nxt = ST_RPT;
`else
          w_state_nxt = ST_IDLE;
`endif
        end else begin
          w_state_nxt = ST_SCAN;
        end
      end
      ST_RPT: begin
        if (w_stall) begin
          w_state_nxt = ST_RPT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: the event the current slot wants to push
  always_comb begin
    w_need_push = 1'b0;
    w_push_data = 5'd0;
    case (r_state)
      ST_SCAN: begin
        if (r_rel_mask[r_slot]) begin
          w_need_push = 1'b1;
          w_push_data = {r_slot, KIND_RELEASE};
        end else if (r_press_mask[r_slot]) begin
          w_need_push = 1'b1;
          w_push_data = {r_slot, KIND_PRESS};
        end else begin
          w_need_push = 1'b0;
          w_push_data = 5'd0;
        end
      end
      ST_RPT: begin
`ifdef NES_EVENTS_REPEAT_EN
        if (r_fire) begin
          w_need_push = 1'b1;
          w_push_data = {r_rpt_btn, KIND_REPEAT};
        end else begin
          w_need_push = 1'b0;
          w_push_data = 5'd0;
        end
`else
        w_need_push = 1'b0;
        w_push_data = 5'd0;
`endif
      end
      default: begin
        w_need_push = 1'b0;
        w_push_data = 5'd0;
      end
    endcase
  end

  // Event FIFO storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 5'd0;
      end
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_push_data;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Event fields read as zero while the FIFO is empty.
  assign o_event_valid  = w_not_empty;
  assign o_event_button = w_not_empty ? w_head[4:2] : 3'd0;
  assign o_event_kind   = w_not_empty ? w_head[1:0] : 2'd0;
  assign o_buttons_held = r_held;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_nes_button_events.sv
module tb_nes_button_events;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_valid;
  logic [7:0] i_buttons;
  logic       o_event_valid;
  logic       i_event_ready;
  logic [2:0] o_event_button;
  logic [1:0] o_event_kind;
  logic [7:0] o_buttons_held;
  logic       o_busy;
  logic       o_overflow;

  always #5 clk = ~clk;

  nes_button_events #(
    .REPEAT_DELAY(3),
    .REPEAT_RATE (2),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk           (clk),
    .i_rst_n       (i_rst_n),
    .i_valid       (i_valid),
    .i_buttons     (i_buttons),
    .o_event_valid (o_event_valid),
    .i_event_ready (i_event_ready),
    .o_event_button(o_event_button),
    .o_event_kind  (o_event_kind),
    .o_buttons_held(o_buttons_held),
    .o_busy        (o_busy),
    .o_overflow    (o_overflow)
  );

  localparam logic [1:0] K_PRESS = 2'd0;
  localparam logic [1:0] K_REL   = 2'd1;
`ifdef NES_EVENTS_REPEAT_EN
  localparam logic [1:0] K_RPT   = 2'd2;
  localparam int BUSY_CYCLES = 9;
`else
  localparam int BUSY_CYCLES = 8;
`endif

  typedef struct packed {
    logic [7:0]      buttons;
    logic [7:0]      held;
    logic [1:0]      n_ev;
    logic [2:0][4:0] ev;
  } vec_t;

  vec_t       vecs [9];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [4:0] got_q [$];
  logic [4:0] exp_q [$];

  // Record every handshake; inputs change only just after rising edges.
  always @(negedge clk) begin
    if (i_rst_n && o_event_valid && i_event_ready) begin
      got_q.push_back({o_event_button, o_event_kind});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [4:0] ev(input logic [2:0] b, input logic [1:0] k);
    return {b, k};
  endfunction

  function automatic vec_t mk(input logic [7:0] b, input logic [7:0] h, input logic [1:0] n,
                              input logic [4:0] e0, input logic [4:0] e1, input logic [4:0] e2);
    vec_t v;
    v.buttons = b;
    v.held    = h;
    v.n_ev    = n;
    v.ev[0]   = e0;
    v.ev[1]   = e1;
    v.ev[2]   = e2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [7:0] b);
    i_valid   = 1'b1;
    i_buttons = b;
    tick();
    i_valid   = 1'b0;
  endtask

  task automatic run_to_idle(output int n);
    n = 0;
    while (o_busy && n < 40) begin
      n++;
      tick();
    end
    if (o_busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got busy expected idle");
    end
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic check_events(input string name);
    int n;
    check({name, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_ev%0d", name, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;

    vecs[0] = mk(8'h00, 8'h00, 2'd0, 5'd0, 5'd0, 5'd0);
    vecs[1] = mk(8'h09, 8'h09, 2'd2, ev(3'd0, K_PRESS), ev(3'd3, K_PRESS), 5'd0);
    vecs[2] = mk(8'h08, 8'h08, 2'd1, ev(3'd0, K_REL), 5'd0, 5'd0);
    vecs[3] = mk(8'h30, 8'h30, 2'd3, ev(3'd3, K_REL), ev(3'd4, K_PRESS), ev(3'd5, K_PRESS));
    vecs[4] = mk(8'h20, 8'h20, 2'd1, ev(3'd4, K_REL), 5'd0, 5'd0);
    vecs[5] = mk(8'h00, 8'h00, 2'd1, ev(3'd5, K_REL), 5'd0, 5'd0);
    vecs[6] = mk(8'h81, 8'h81, 2'd2, ev(3'd0, K_PRESS), ev(3'd7, K_PRESS), 5'd0);
    vecs[7] = mk(8'h80, 8'h80, 2'd1, ev(3'd0, K_REL), 5'd0, 5'd0);
    vecs[8] = mk(8'h00, 8'h00, 2'd1, ev(3'd7, K_REL), 5'd0, 5'd0);

    // Reset held while i_valid pulses
    i_rst_n       = 1'b0;
    i_valid       = 1'b0;
    i_buttons     = 8'hFF;
    i_event_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_valid = ~i_valid;
      tick();
    end
    check("rst_valid",   o_event_valid,  1'b0);
    check("rst_button",  o_event_button, 3'd0);
    check("rst_kind",    o_event_kind,   2'd0);
    check("rst_held",    o_buttons_held, 8'h00);
    check("rst_busy",    o_busy,         1'b0);
    check("rst_ovf",     o_overflow,     1'b0);
    i_valid   = 1'b0;
    i_buttons = 8'h00;
    i_rst_n   = 1'b1;
    tick();
    got_q.delete();

    // Table-driven samples, consumer always ready
    for (int i = 0; i < 9; i++) begin
      send_sample(vecs[i].buttons);
      check($sformatf("v%0d_held", i), o_buttons_held, vecs[i].held);
      run_to_idle(n);
      check($sformatf("v%0d_busy_cycles", i), n, BUSY_CYCLES);
      drain(3);
      for (int j = 0; j < int'(vecs[i].n_ev); j++) exp_q.push_back(vecs[i].ev[j]);
      check_events($sformatf("v%0d", i));
    end

    // Earliest event is visible two cycles after the strobe
    send_sample(8'h01);
    check("lat_t1_valid", o_event_valid, 1'b0);
    tick();
    check("lat_t2_valid", o_event_valid, 1'b1);
    check("lat_t2_head", {o_event_button, o_event_kind}, ev(3'd0, K_PRESS));
    run_to_idle(n);
    drain(3);
    exp_q.push_back(ev(3'd0, K_PRESS));
    check_events("lat");
    send_sample(8'h00);
    run_to_idle(n);
    drain(3);
    exp_q.push_back(ev(3'd0, K_REL));
    check_events("lat_rel");

    // Backpressure: full FIFO stalls the scanner, nothing is lost
    i_event_ready = 1'b0;
    send_sample(8'hFF);
    drain(12);
    check("stall_busy",  o_busy,        1'b1);
    check("stall_valid", o_event_valid, 1'b1);
    check("stall_head",  {o_event_button, o_event_kind}, ev(3'd0, K_PRESS));
    check("stall_nopop", got_q.size(),  0);
    i_event_ready = 1'b1;
    run_to_idle(n);
    drain(6);
    for (int b = 0; b < 8; b++) exp_q.push_back(ev(3'(b), K_PRESS));
    check_events("stall");
    send_sample(8'h00);
    run_to_idle(n);
    drain(3);
    for (int b = 0; b < 8; b++) exp_q.push_back(ev(3'(b), K_REL));
    check_events("stall_rel");
    check("stall_ovf", o_overflow, 1'b0);

    // Second strobe two cycles after the first is dropped
    send_sample(8'h02);
    tick();
    i_valid   = 1'b1;
    i_buttons = 8'h04;
    check("ovf_before", o_overflow, 1'b0);
    tick();
    i_valid = 1'b0;
    check("ovf_after", o_overflow, 1'b1);
    run_to_idle(n);
    drain(3);
    check("ovf_held", o_buttons_held, 8'h02);
    exp_q.push_back(ev(3'd1, K_PRESS));
    check_events("ovf");

    // Reset in the middle of a stalled scan flushes everything
    i_event_ready = 1'b0;
    send_sample(8'hF0);
    drain(2);
    i_rst_n = 1'b0;
    tick();
    check("mrst_valid", o_event_valid,  1'b0);
    check("mrst_held",  o_buttons_held, 8'h00);
    check("mrst_busy",  o_busy,         1'b0);
    check("mrst_ovf",   o_overflow,     1'b0);
    i_rst_n       = 1'b1;
    i_event_ready = 1'b1;
    drain(12);
    check("mrst_busy_after",  o_busy,        1'b0);
    check("mrst_valid_after", o_event_valid, 1'b0);
    check_events("mrst");

    // Button A held over 8 samples
    for (int s = 1; s <= 8; s++) begin
      send_sample(8'h01);
      run_to_idle(n);
      if (s == 1) check("rpt_busy_cycles", n, BUSY_CYCLES);
    end
    drain(3);
    exp_q.push_back(ev(3'd0, K_PRESS));
`ifdef NES_EVENTS_REPEAT_EN
    for (int r = 0; r < 3; r++) exp_q.push_back(ev(3'd0, K_RPT));
`endif
    check_events("rpt");
    send_sample(8'h00);
    run_to_idle(n);
    drain(3);
    exp_q.push_back(ev(3'd0, K_REL));
    check_events("rpt_rel");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
